// File: rtl/mini_fpga_fabric_pkg.sv
// Shared sizes and config field layout for the mini FPGA fabric.
package mini_fpga_fabric_pkg;

  localparam int N_CLB     = 8;
  localparam int CLB_BITS  = 37;
  localparam int CLB_TOTAL = N_CLB * CLB_BITS;
  localparam int N_PIN     = 32;
  localparam int CB_FIELD  = 6;
  localparam int CB_BITS   = N_PIN * CB_FIELD;
  localparam int SB_BITS   = 3072;
  localparam int SB_USED   = N_PIN * N_PIN;
  localparam int SB2_BITS  = 1536;

  localparam int LUT_LSB    = 0;
  localparam int LUT_W      = 16;
  localparam int SEL_A0_LSB = 16;
  localparam int SEL_W      = 5;
  localparam int REG_EN_BIT = 36;

  // One pin driver's slice of the CB chain, MSB first.
  typedef struct packed {
    logic       reserved;
    logic       oe;
    logic       invert;
    logic [2:0] clb_idx;
  } cb_field_t;

endpackage

// File: rtl/mini_fpga_fabric_if.sv
// Configuration bus: global program enable, per-chain shift enables and serial data.
interface mini_fpga_fabric_if;

  logic prgm_b;
  logic CLB_prgm_b;
  logic CLB_prgm_b_in;
  logic cb_prgm_b;
  logic cb_prgm_b_in;
  logic sb_prgm_b;
  logic sb_prgm_b_in;
  logic sb_prgm_b_2;
  logic bit_in_CLB;
  logic bit_in_CB;
  logic bit_in_SB;
  logic bit_in_SB_2;

  modport master (
    output prgm_b, CLB_prgm_b, CLB_prgm_b_in, cb_prgm_b, cb_prgm_b_in,
           sb_prgm_b, sb_prgm_b_in, sb_prgm_b_2,
           bit_in_CLB, bit_in_CB, bit_in_SB, bit_in_SB_2
  );

  modport slave (
    input  prgm_b, CLB_prgm_b, CLB_prgm_b_in, cb_prgm_b, cb_prgm_b_in,
           sb_prgm_b, sb_prgm_b_in, sb_prgm_b_2,
           bit_in_CLB, bit_in_CB, bit_in_SB, bit_in_SB_2
  );

endinterface

// File: rtl/mini_fpga_fabric_clb.sv
// One logic cell: four pin-selected inputs into a LUT4, optional output register.
module fabric_clb
  import mini_fpga_fabric_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                prgm_b,
  input  logic [CLB_BITS-1:0] cfg_bits,
  input  logic [N_PIN-1:0]    pins,
  output logic                out
);

  logic [3:0]       lut_idx;
  logic [LUT_W-1:0] truth;
  logic             lut_out;
  logic             ff_q;

  for (genvar i = 0; i < 4; i++) begin : g_sel
    assign lut_idx[i] = pins[cfg_bits[SEL_A0_LSB + i*SEL_W +: SEL_W]];
  end

  assign truth   = cfg_bits[LUT_LSB +: LUT_W];
  assign lut_out = truth[lut_idx];

  // The register only advances in user mode so configuration never disturbs it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff_q <= 1'b0;
    end else if (prgm_b) begin
      ff_q <= lut_out;
    end
  end

  assign out = cfg_bits[REG_EN_BIT] ? ff_q : lut_out;

endmodule

// File: rtl/mini_fpga_fabric.sv
// Fabric top: serial config chains, eight CLBs, per-pin drivers and the pin-to-pin switch matrix.
module mini_fpga_fabric
  import mini_fpga_fabric_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mini_fpga_fabric_if.slave cfg,
  inout  wire               V0_0, V0_1, V0_2, V0_3, V0_4, V0_5, V0_6, V0_7,
  inout  wire               V1_0, V1_1, V1_2, V1_3, V1_4, V1_5, V1_6, V1_7,
  inout  wire               H0_0, H0_1, H0_2, H0_3, H0_4, H0_5, H0_6, H0_7,
  inout  wire               H1_0, H1_1, H1_2, H1_3, H1_4, H1_5, H1_6, H1_7
);

  logic [CLB_TOTAL-1:0] clb_chain;
  logic [CB_BITS-1:0]   cb_chain;
  logic [SB_BITS-1:0]   sb_chain;
  logic [SB2_BITS-1:0]  sb2_chain;

  logic [N_PIN-1:0] pin_in;
  logic [N_PIN-1:0] pin_oe;
  logic [N_PIN-1:0] pin_val;
  logic [N_CLB-1:0] clb_out;

  // New bits enter at the MSB so the first bit streamed ends up at index 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clb_chain <= '0;
      cb_chain  <= '0;
      sb_chain  <= '0;
      sb2_chain <= '0;
    end else if (!cfg.prgm_b) begin
      if (cfg.CLB_prgm_b && cfg.CLB_prgm_b_in)
        clb_chain <= {cfg.bit_in_CLB, clb_chain[CLB_TOTAL-1:1]};
      if (cfg.cb_prgm_b && cfg.cb_prgm_b_in)
        cb_chain <= {cfg.bit_in_CB, cb_chain[CB_BITS-1:1]};
      if (cfg.sb_prgm_b && cfg.sb_prgm_b_in)
        sb_chain <= {cfg.bit_in_SB, sb_chain[SB_BITS-1:1]};
      if (cfg.sb_prgm_b_2)
        sb2_chain <= {cfg.bit_in_SB_2, sb2_chain[SB2_BITS-1:1]};
    end
  end

  for (genvar k = 0; k < N_CLB; k++) begin : g_clb
    fabric_clb u_clb (
      .clk      (clk),
      .reset    (reset),
      .prgm_b   (cfg.prgm_b),
      .cfg_bits (clb_chain[k*CLB_BITS +: CLB_BITS]),
      .pins     (pin_in),
      .out      (clb_out[k])
    );
  end

  // A CB-enabled pin takes priority; otherwise any selected SB source ORs onto it.
  always_comb begin
    cb_field_t        cb_f;
    logic [N_PIN-1:0] sb_sel;
    pin_oe  = '0;
    pin_val = '0;
    cb_f    = '0;
    sb_sel  = '0;
    for (int p = 0; p < N_PIN; p++) begin
      cb_f   = cb_field_t'(cb_chain[p*CB_FIELD +: CB_FIELD]);
      sb_sel = sb_chain[p*N_PIN +: N_PIN];
      if (cfg.prgm_b) begin
        if (cb_f.oe) begin
          pin_oe[p]  = 1'b1;
          pin_val[p] = clb_out[cb_f.clb_idx] ^ cb_f.invert;
        end else if (|sb_sel) begin
          pin_oe[p]  = 1'b1;
          pin_val[p] = |(sb_sel & pin_in);
        end
      end
    end
  end

  assign pin_in = {H1_7, H1_6, H1_5, H1_4, H1_3, H1_2, H1_1, H1_0,
                   H0_7, H0_6, H0_5, H0_4, H0_3, H0_2, H0_1, H0_0,
                   V1_7, V1_6, V1_5, V1_4, V1_3, V1_2, V1_1, V1_0,
                   V0_7, V0_6, V0_5, V0_4, V0_3, V0_2, V0_1, V0_0};

  assign V0_0 = pin_oe[0]  ? pin_val[0]  : 1'bz;
  assign V0_1 = pin_oe[1]  ? pin_val[1]  : 1'bz;
  assign V0_2 = pin_oe[2]  ? pin_val[2]  : 1'bz;
  assign V0_3 = pin_oe[3]  ? pin_val[3]  : 1'bz;
  assign V0_4 = pin_oe[4]  ? pin_val[4]  : 1'bz;
  assign V0_5 = pin_oe[5]  ? pin_val[5]  : 1'bz;
  assign V0_6 = pin_oe[6]  ? pin_val[6]  : 1'bz;
  assign V0_7 = pin_oe[7]  ? pin_val[7]  : 1'bz;
  assign V1_0 = pin_oe[8]  ? pin_val[8]  : 1'bz;
  assign V1_1 = pin_oe[9]  ? pin_val[9]  : 1'bz;
  assign V1_2 = pin_oe[10] ? pin_val[10] : 1'bz;
  assign V1_3 = pin_oe[11] ? pin_val[11] : 1'bz;
  assign V1_4 = pin_oe[12] ? pin_val[12] : 1'bz;
  assign V1_5 = pin_oe[13] ? pin_val[13] : 1'bz;
  assign V1_6 = pin_oe[14] ? pin_val[14] : 1'bz;
  assign V1_7 = pin_oe[15] ? pin_val[15] : 1'bz;
  assign H0_0 = pin_oe[16] ? pin_val[16] : 1'bz;
  assign H0_1 = pin_oe[17] ? pin_val[17] : 1'bz;
  assign H0_2 = pin_oe[18] ? pin_val[18] : 1'bz;
  assign H0_3 = pin_oe[19] ? pin_val[19] : 1'bz;
  assign H0_4 = pin_oe[20] ? pin_val[20] : 1'bz;
  assign H0_5 = pin_oe[21] ? pin_val[21] : 1'bz;
  assign H0_6 = pin_oe[22] ? pin_val[22] : 1'bz;
  assign H0_7 = pin_oe[23] ? pin_val[23] : 1'bz;
  assign H1_0 = pin_oe[24] ? pin_val[24] : 1'bz;
  assign H1_1 = pin_oe[25] ? pin_val[25] : 1'bz;
  assign H1_2 = pin_oe[26] ? pin_val[26] : 1'bz;
  assign H1_3 = pin_oe[27] ? pin_val[27] : 1'bz;
  assign H1_4 = pin_oe[28] ? pin_val[28] : 1'bz;
  assign H1_5 = pin_oe[29] ? pin_val[29] : 1'bz;
  assign H1_6 = pin_oe[30] ? pin_val[30] : 1'bz;
  assign H1_7 = pin_oe[31] ? pin_val[31] : 1'bz;

endmodule

// File: tb/tb_mini_fpga_fabric.sv
// Directed bench for mini_fpga_fabric: loads whole config images serially and probes the pins.
module tb_mini_fpga_fabric;
  import mini_fpga_fabric_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [N_PIN-1:0] tb_en;
  logic [N_PIN-1:0] tb_val;
  wire  [N_PIN-1:0] pin;

  logic [CLB_TOTAL-1:0] clb_img;
  logic [CB_BITS-1:0]   cb_img;
  logic [SB_BITS-1:0]   sb_img;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int               cfg_id;
    logic [N_PIN-1:0] en;
    logic [N_PIN-1:0] val;
    int               pin_idx;
    logic             exp;
  } vec_t;

  vec_t vecs[16];

  mini_fpga_fabric_if cfg_bus ();

  always #5 clk = ~clk;

  for (genvar i = 0; i < N_PIN; i++) begin : g_drv
    assign pin[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  mini_fpga_fabric dut (
    .clk   (clk),
    .reset (reset),
    .cfg   (cfg_bus.slave),
    .V0_0 (pin[0]),  .V0_1 (pin[1]),  .V0_2 (pin[2]),  .V0_3 (pin[3]),
    .V0_4 (pin[4]),  .V0_5 (pin[5]),  .V0_6 (pin[6]),  .V0_7 (pin[7]),
    .V1_0 (pin[8]),  .V1_1 (pin[9]),  .V1_2 (pin[10]), .V1_3 (pin[11]),
    .V1_4 (pin[12]), .V1_5 (pin[13]), .V1_6 (pin[14]), .V1_7 (pin[15]),
    .H0_0 (pin[16]), .H0_1 (pin[17]), .H0_2 (pin[18]), .H0_3 (pin[19]),
    .H0_4 (pin[20]), .H0_5 (pin[21]), .H0_6 (pin[22]), .H0_7 (pin[23]),
    .H1_0 (pin[24]), .H1_1 (pin[25]), .H1_2 (pin[26]), .H1_3 (pin[27]),
    .H1_4 (pin[28]), .H1_5 (pin[29]), .H1_6 (pin[30]), .H1_7 (pin[31])
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [N_PIN-1:0] en, input logic [N_PIN-1:0] val);
    tb_en  = en;
    tb_val = val;
  endtask

  task automatic set_clb(input int k, input logic [15:0] lut, input logic [4:0] s0,
                         input logic [4:0] s1, input logic reg_en);
    clb_img[k*CLB_BITS +: 16]      = lut;
    clb_img[k*CLB_BITS + 16 +: 5]  = s0;
    clb_img[k*CLB_BITS + 21 +: 5]  = s1;
    clb_img[k*CLB_BITS + 26 +: 5]  = 5'd0;
    clb_img[k*CLB_BITS + 31 +: 5]  = 5'd0;
    clb_img[k*CLB_BITS + 36]       = reg_en;
  endtask

  // Images: 0/1/4 = CLB0 AND(pin0,pin1) onto pin16 (1 inverted, 4 registered),
  // 2 = SB 24<-8, 3 = SB 24<-{8,9}, 25<-8 overridden by CB from CLB5 (constant 1).
  task automatic build_config(input int id);
    clb_img = '0;
    cb_img  = '0;
    sb_img  = '0;
    case (id)
      0, 1, 4: begin
        set_clb(0, 16'h8888, 5'd0, 5'd1, id == 4);
        cb_img[16*CB_FIELD +: CB_FIELD] = (id == 1) ? 6'b011000 : 6'b010000;
      end
      2: sb_img[24*N_PIN + 8] = 1'b1;
      3: begin
        sb_img[24*N_PIN + 8] = 1'b1;
        sb_img[24*N_PIN + 9] = 1'b1;
        sb_img[25*N_PIN + 8] = 1'b1;
        set_clb(5, 16'hFFFF, 5'd0, 5'd0, 1'b0);
        cb_img[25*CB_FIELD +: CB_FIELD] = 6'b010101;
      end
      default: ;
    endcase
  endtask

  task automatic clear_enables();
    cfg_bus.CLB_prgm_b = 1'b0; cfg_bus.CLB_prgm_b_in = 1'b0;
    cfg_bus.cb_prgm_b  = 1'b0; cfg_bus.cb_prgm_b_in  = 1'b0;
    cfg_bus.sb_prgm_b  = 1'b0; cfg_bus.sb_prgm_b_in  = 1'b0;
    cfg_bus.sb_prgm_b_2 = 1'b0;
    cfg_bus.bit_in_CLB = 1'b0; cfg_bus.bit_in_CB = 1'b0;
    cfg_bus.bit_in_SB  = 1'b0; cfg_bus.bit_in_SB_2 = 1'b0;
  endtask

  // All chains shift together; each stops once its full image is in.
  task automatic load_config(input int id);
    build_config(id);
    @(negedge clk);
    cfg_bus.prgm_b = 1'b0;
    for (int i = 0; i < SB_BITS; i++) begin
      @(negedge clk);
      cfg_bus.CLB_prgm_b    = (i < CLB_TOTAL);
      cfg_bus.CLB_prgm_b_in = (i < CLB_TOTAL);
      cfg_bus.bit_in_CLB    = (i < CLB_TOTAL) ? clb_img[i] : 1'b0;
      cfg_bus.cb_prgm_b     = (i < CB_BITS);
      cfg_bus.cb_prgm_b_in  = (i < CB_BITS);
      cfg_bus.bit_in_CB     = (i < CB_BITS) ? cb_img[i] : 1'b0;
      cfg_bus.sb_prgm_b     = 1'b1;
      cfg_bus.sb_prgm_b_in  = 1'b1;
      cfg_bus.bit_in_SB     = sb_img[i];
      cfg_bus.sb_prgm_b_2   = (i < SB2_BITS);
      cfg_bus.bit_in_SB_2   = i[0];
    end
    @(negedge clk);
    clear_enables();
  endtask

  task automatic check_hiz(input string tag);
    apply_stimulus('1, '0);
    #1 check_output({tag, "_drive0"}, pin, 32'h0000_0000);
    apply_stimulus('1, '1);
    #1 check_output({tag, "_drive1"}, pin, 32'hFFFF_FFFF);
    apply_stimulus('0, '0);
  endtask

  initial begin
    int cur_cfg;

    vecs[0]  = '{0, 32'h0000_0003, 32'h0000_0003, 16, 1'b1};
    vecs[1]  = '{0, 32'h0000_0003, 32'h0000_0001, 16, 1'b0};
    vecs[2]  = '{0, 32'h0000_0003, 32'h0000_0002, 16, 1'b0};
    vecs[3]  = '{0, 32'h0000_0003, 32'h0000_0000, 16, 1'b0};
    vecs[4]  = '{0, 32'h0000_0003, 32'h0000_0003, 16, 1'b1};
    vecs[5]  = '{0, 32'h0002_0003, 32'h0002_0003, 17, 1'b1};
    vecs[6]  = '{0, 32'h0002_0003, 32'h0000_0003, 17, 1'b0};
    vecs[7]  = '{1, 32'h0000_0003, 32'h0000_0003, 16, 1'b0};
    vecs[8]  = '{1, 32'h0000_0003, 32'h0000_0001, 16, 1'b1};
    vecs[9]  = '{2, 32'h0000_0100, 32'h0000_0100, 24, 1'b1};
    vecs[10] = '{2, 32'h0000_0100, 32'h0000_0000, 24, 1'b0};
    vecs[11] = '{3, 32'h0000_0303, 32'h0000_0200, 24, 1'b1};
    vecs[12] = '{3, 32'h0000_0303, 32'h0000_0100, 24, 1'b1};
    vecs[13] = '{3, 32'h0000_0303, 32'h0000_0000, 24, 1'b0};
    vecs[14] = '{3, 32'h0000_0303, 32'h0000_0000, 25, 1'b1};
    vecs[15] = '{3, 32'h0000_0303, 32'h0000_0100, 25, 1'b1};

    reset = 1'b0;
    cfg_bus.prgm_b = 1'b0;
    clear_enables();
    apply_stimulus('0, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cfg_bus.prgm_b = 1'b1;
    check_hiz("reset_pins");

    cur_cfg = -1;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].cfg_id != cur_cfg) begin
        load_config(vecs[i].cfg_id);
        cur_cfg = vecs[i].cfg_id;
      end
      @(negedge clk);
      cfg_bus.prgm_b = 1'b1;
      apply_stimulus(vecs[i].en, vecs[i].val);
      #1 check_output($sformatf("vec%0d_pin%0d", i, vecs[i].pin_idx),
                      {31'b0, pin[vecs[i].pin_idx]}, {31'b0, vecs[i].exp});
    end

    // Registered output: the last image left CLB0's LUT at 0, so the flop starts at 0.
    load_config(4);
    cfg_bus.prgm_b = 1'b1;
    apply_stimulus(32'h3, 32'h3);
    #1 check_output("reg_before_edge", {31'b0, pin[16]}, 32'd0);
    @(posedge clk);
    #1 check_output("reg_after_edge", {31'b0, pin[16]}, 32'd1);
    @(negedge clk);
    apply_stimulus(32'h3, 32'h1);
    #1 check_output("reg_hold_until_edge", {31'b0, pin[16]}, 32'd1);
    @(posedge clk);
    #1 check_output("reg_fall_on_edge", {31'b0, pin[16]}, 32'd0);
    @(negedge clk);
    apply_stimulus(32'h3, 32'h3);
    @(posedge clk);
    #1 check_output("reg_rise_again", {31'b0, pin[16]}, 32'd1);

    // Dropping prgm_b releases the pin and freezes the flop.
    @(negedge clk);
    cfg_bus.prgm_b = 1'b0;
    apply_stimulus(32'h0001_0003, 32'h0000_0003);
    #1 check_output("prog_pin_released", {31'b0, pin[16]}, 32'd0);
    apply_stimulus(32'h0001_0003, 32'h0000_0001);
    @(posedge clk);
    @(negedge clk);
    apply_stimulus(32'h3, 32'h1);
    cfg_bus.prgm_b = 1'b1;
    #1 check_output("prog_ff_held", {31'b0, pin[16]}, 32'd1);
    @(posedge clk);
    #1 check_output("user_ff_resumes", {31'b0, pin[16]}, 32'd0);

    // Reset partway through a CLB load must wipe every chain, including the earlier CB/SB image.
    load_config(3);
    build_config(0);
    cfg_bus.prgm_b = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      cfg_bus.CLB_prgm_b    = 1'b1;
      cfg_bus.CLB_prgm_b_in = 1'b1;
      cfg_bus.bit_in_CLB    = clb_img[i];
    end
    @(negedge clk);
    reset = 1'b0;
    clear_enables();
    check_hiz("midload_in_reset");
    @(negedge clk);
    reset = 1'b1;
    cfg_bus.prgm_b = 1'b1;
    check_hiz("midload_after_reset");
    @(posedge clk);
    #1 check_hiz("midload_after_edge");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
